// File: rtl/sine_pkg.sv
// Shared constants and types for the sine sample generator.
package sine_pkg;

    localparam int SAMPLE_W = 8;
    localparam int PHASE_W  = 6;

    // Quarter-wave table, round(127*sin(2*pi*k/64)) for k = 0..16.
    localparam logic [SAMPLE_W-1:0] SINE_LUT [17] = '{
        8'd0,   8'd12,  8'd25,  8'd37,  8'd49,  8'd60,  8'd71,  8'd81,
        8'd90,  8'd98,  8'd106, 8'd112, 8'd117, 8'd122, 8'd125, 8'd126,
        8'd127
    };

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/sine_sample_gen_if.sv
// Control/sample bundle between a sine generator and its consumer.
interface sine_sample_gen_if #(
    parameter int DIV_W    = 16,
    parameter int SAMPLE_W = 8
);
    logic                       en;
    logic                       restart;
    logic [DIV_W-1:0]           div;
    logic signed [SAMPLE_W-1:0] sample_o;
    logic                       valid_o;
    logic [5:0]                 phase_o;

    modport master (
        output en, restart, div,
        input  sample_o, valid_o, phase_o
    );

    modport slave (
        input  en, restart, div,
        output sample_o, valid_o, phase_o
    );
endinterface

// File: rtl/sine_quarter_lut.sv
// Combinational quarter-wave ROM; indices above 16 read as zero.
module sine_quarter_lut
    import sine_pkg::*;
(
    input  logic [4:0]          idx_i,
    output logic [SAMPLE_W-1:0] mag_o
);

    always_comb begin
        mag_o = '0;
        if (idx_i <= 5'd16) begin
            mag_o = SINE_LUT[idx_i];
        end
    end

endmodule

// File: rtl/sine_sample_gen.sv
// Divided-clock sine sample source: 64 samples per period, registered outputs.
module sine_sample_gen #(
    parameter int DIV_W    = 16,
    parameter int SAMPLE_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    sine_sample_gen_if.slave bus
);
    import sine_pkg::*;

    state_t                     state_q, state_d;
    logic [DIV_W-1:0]           cnt_q, cnt_d;
    logic [PHASE_W-1:0]         ph_q, ph_d;
    logic signed [SAMPLE_W-1:0] sample_q, sample_d;
    logic [PHASE_W-1:0]         phase_q, phase_d;
    logic                       valid_q, valid_d;

    logic                         run;
    logic [4:0]                   lut_idx;
    logic [sine_pkg::SAMPLE_W-1:0] mag;
    logic signed [SAMPLE_W-1:0]   mag_ext;
    logic signed [SAMPLE_W-1:0]   sine_val;

    // Odd quadrants read the table backwards; the upper half is negated.
    always_comb begin
        lut_idx = ph_q[4] ? (5'd16 - {1'b0, ph_q[3:0]}) : {1'b0, ph_q[3:0]};
    end

    sine_quarter_lut u_lut (
        .idx_i (lut_idx),
        .mag_o (mag)
    );

    always_comb begin
        mag_ext  = SAMPLE_W'(mag);
        sine_val = ph_q[5] ? -mag_ext : mag_ext;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ph_d     = ph_q;
        sample_d = sample_q;
        phase_d  = phase_q;
        valid_d  = 1'b0;
        run      = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.en) begin
                    state_d = RUN;
                    run     = 1'b1;
                end
            end
            RUN: begin
                if (!bus.en) begin
                    state_d = IDLE;
                end else begin
                    run = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Restart wins over a coincident tick in either state.
        if (bus.restart) begin
            cnt_d = '0;
            ph_d  = '0;
        end else if (run) begin
            if (cnt_q >= bus.div) begin
                cnt_d    = '0;
                ph_d     = ph_q + 1'b1;
                sample_d = sine_val;
                phase_d  = ph_q;
                valid_d  = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            ph_q     <= '0;
            sample_q <= '0;
            phase_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ph_q     <= ph_d;
            sample_q <= sample_d;
            phase_q  <= phase_d;
            valid_q  <= valid_d;
        end
    end

    assign bus.sample_o = sample_q;
    assign bus.valid_o  = valid_q;
    assign bus.phase_o  = phase_q;

endmodule

// File: tb/tb_sine_sample_gen.sv
// Directed self-checking bench for sine_sample_gen.
module tb_sine_sample_gen;

    localparam int DIV_W    = 16;
    localparam int SAMPLE_W = 8;

    // Expected sample per phase, worked out by hand from the quarter table.
    localparam int EXP [64] = '{
           0,   12,   25,   37,   49,   60,   71,   81,
          90,   98,  106,  112,  117,  122,  125,  126,
         127,  126,  125,  122,  117,  112,  106,   98,
          90,   81,   71,   60,   49,   37,   25,   12,
           0,  -12,  -25,  -37,  -49,  -60,  -71,  -81,
         -90,  -98, -106, -112, -117, -122, -125, -126,
        -127, -126, -125, -122, -117, -112, -106,  -98,
         -90,  -81,  -71,  -60,  -49,  -37,  -25,  -12
    };

    logic clk;
    logic rst;
    int   passed;
    int   total;

    sine_sample_gen_if #(.DIV_W(DIV_W), .SAMPLE_W(SAMPLE_W)) bus ();

    sine_sample_gen #(.DIV_W(DIV_W), .SAMPLE_W(SAMPLE_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.en = 1'b0;
        bus.restart = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.en = 1'b1;
        bus.restart = 1'b0;
        bus.div = '0;
        step();
        step();
        total++;
        if (bus.valid_o !== 1'b0) $display("FAIL reset_valid got %0b exp 0", bus.valid_o);
        else passed++;
        total++;
        if (int'(bus.sample_o) !== 0) $display("FAIL reset_sample got %0d exp 0", bus.sample_o);
        else passed++;
        total++;
        if (bus.phase_o !== 6'd0) $display("FAIL reset_phase got %0d exp 0", bus.phase_o);
        else passed++;
        rst = 1'b0;
        bus.en = 1'b0;
        step();
    endtask

    task automatic test_div0_full_period();
        do_reset();
        bus.div = '0;
        bus.en = 1'b1;
        for (int k = 0; k <= 64; k++) begin
            step();
            total++;
            if (bus.valid_o !== 1'b1) $display("FAIL div0_valid k=%0d got %0b exp 1", k, bus.valid_o);
            else passed++;
            total++;
            if (int'(bus.phase_o) !== (k % 64)) $display("FAIL div0_phase k=%0d got %0d exp %0d", k, bus.phase_o, k % 64);
            else passed++;
            total++;
            if (int'(bus.sample_o) !== EXP[k % 64]) $display("FAIL div0_sample k=%0d got %0d exp %0d", k, bus.sample_o, EXP[k % 64]);
            else passed++;
        end
        bus.en = 1'b0;
    endtask

    task automatic test_div3_period();
        do_reset();
        bus.div = 16'd3;
        bus.en = 1'b1;
        for (int n = 1; n <= 24; n++) begin
            step();
            total++;
            if (bus.valid_o !== ((n % 4) == 0)) $display("FAIL div3_valid n=%0d got %0b exp %0b", n, bus.valid_o, (n % 4) == 0);
            else passed++;
            if ((n % 4) == 0) begin
                total++;
                if (int'(bus.phase_o) !== (n / 4 - 1)) $display("FAIL div3_phase n=%0d got %0d exp %0d", n, bus.phase_o, n / 4 - 1);
                else passed++;
            end
        end
        bus.en = 1'b0;
    endtask

    task automatic test_en_pause();
        do_reset();
        bus.div = '0;
        bus.en = 1'b1;
        for (int k = 0; k < 21; k++) step();
        bus.en = 1'b0;
        for (int n = 0; n < 10; n++) begin
            step();
            total++;
            if (bus.valid_o !== 1'b0) $display("FAIL pause_valid n=%0d got %0b exp 0", n, bus.valid_o);
            else passed++;
            total++;
            if (int'(bus.sample_o) !== 117) $display("FAIL pause_sample n=%0d got %0d exp 117", n, bus.sample_o);
            else passed++;
            total++;
            if (bus.phase_o !== 6'd20) $display("FAIL pause_phase n=%0d got %0d exp 20", n, bus.phase_o);
            else passed++;
        end
        bus.en = 1'b1;
        step();
        total++;
        if (bus.valid_o !== 1'b1 || bus.phase_o !== 6'd21 || int'(bus.sample_o) !== 112)
            $display("FAIL pause_resume got v=%0b ph=%0d s=%0d exp v=1 ph=21 s=112", bus.valid_o, bus.phase_o, bus.sample_o);
        else passed++;
        bus.en = 1'b0;
    endtask

    task automatic test_restart();
        do_reset();
        bus.div = '0;
        bus.en = 1'b1;
        for (int k = 0; k < 40; k++) step();
        bus.restart = 1'b1;
        step();
        total++;
        if (bus.valid_o !== 1'b0 || bus.phase_o !== 6'd39 || int'(bus.sample_o) !== -81)
            $display("FAIL restart_suppress got v=%0b ph=%0d s=%0d exp v=0 ph=39 s=-81", bus.valid_o, bus.phase_o, bus.sample_o);
        else passed++;
        bus.restart = 1'b0;
        step();
        total++;
        if (bus.valid_o !== 1'b1 || bus.phase_o !== 6'd0 || int'(bus.sample_o) !== 0)
            $display("FAIL restart_next got v=%0b ph=%0d s=%0d exp v=1 ph=0 s=0", bus.valid_o, bus.phase_o, bus.sample_o);
        else passed++;
        bus.en = 1'b0;
    endtask

    task automatic test_reset_mid_period();
        do_reset();
        bus.div = '0;
        bus.en = 1'b1;
        for (int k = 0; k < 51; k++) step();
        bus.div = 16'd5;
        for (int k = 0; k < 3; k++) step();
        rst = 1'b1;
        bus.restart = 1'b0;
        step();
        total++;
        if (bus.valid_o !== 1'b0 || bus.phase_o !== 6'd0 || int'(bus.sample_o) !== 0)
            $display("FAIL rstmid_outputs got v=%0b ph=%0d s=%0d exp v=0 ph=0 s=0", bus.valid_o, bus.phase_o, bus.sample_o);
        else passed++;
        rst = 1'b0;
        for (int n = 1; n <= 6; n++) begin
            step();
            total++;
            if (bus.valid_o !== (n == 6)) $display("FAIL rstmid_valid n=%0d got %0b exp %0b", n, bus.valid_o, n == 6);
            else passed++;
        end
        total++;
        if (bus.phase_o !== 6'd0 || int'(bus.sample_o) !== 0)
            $display("FAIL rstmid_first got ph=%0d s=%0d exp ph=0 s=0", bus.phase_o, bus.sample_o);
        else passed++;
        bus.en = 1'b0;
    endtask

    task automatic test_div_change();
        do_reset();
        bus.div = 16'd9;
        bus.en = 1'b1;
        for (int n = 1; n <= 6; n++) begin
            step();
            total++;
            if (bus.valid_o !== 1'b0) $display("FAIL divchg_pre n=%0d got %0b exp 0", n, bus.valid_o);
            else passed++;
        end
        bus.div = 16'd2;
        step();
        total++;
        if (bus.valid_o !== 1'b1 || bus.phase_o !== 6'd0)
            $display("FAIL divchg_immediate got v=%0b ph=%0d exp v=1 ph=0", bus.valid_o, bus.phase_o);
        else passed++;
        for (int n = 1; n <= 6; n++) begin
            step();
            total++;
            if (bus.valid_o !== ((n % 3) == 0)) $display("FAIL divchg_valid n=%0d got %0b exp %0b", n, bus.valid_o, (n % 3) == 0);
            else passed++;
            if ((n % 3) == 0) begin
                total++;
                if (int'(bus.phase_o) !== n / 3) $display("FAIL divchg_phase n=%0d got %0d exp %0d", n, bus.phase_o, n / 3);
                else passed++;
            end
        end
        bus.en = 1'b0;
    endtask

    initial begin
        passed = 0;
        total = 0;
        rst = 1'b1;
        bus.en = 1'b0;
        bus.restart = 1'b0;
        bus.div = '0;
        test_reset();
        test_div0_full_period();
        test_div3_period();
        test_en_pause();
        test_restart();
        test_reset_mid_period();
        test_div_change();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/sine_sample_gen.md
SINE_SAMPLE_GEN -- requirements
Module: sine_sample_gen

Interface
REQ-001 Parameter: DIV_W, default 16, width of the sample-period divider.
REQ-002 Parameter: SAMPLE_W, default 8, signed sample width.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst  input  1  reset, synchronous and active-high.
REQ-005 Port: en  input  1  run enable; low freezes the generator.
REQ-006 Port: restart  input  1  synchronous phase restart strobe.
REQ-007 Port: div  input  DIV_W  sample period minus one, in clk cycles.
REQ-008 Port: sample_o  output  SAMPLE_W  signed sine sample, registered, feeds the downstream delay-line/summer chain.
REQ-009 Port: valid_o  output  1  one-cycle strobe marking a new sample_o.
REQ-010 Port: phase_o  output  6  phase index (0..63) of the sample currently on sample_o.

Function
REQ-011 The block SHALL keep a divider counter cnt and a 6-bit phase register ph, 64 samples per sine period.
REQ-012 With en=1 and restart=0, a tick SHALL occur when cnt >= div; on a tick cnt returns to 0, otherwise cnt increments.
REQ-013 On a tick, the next cycle SHALL have sample_o = sine(ph), phase_o = ph, valid_o = 1, and ph SHALL increment modulo 64 (63 wraps to 0).
REQ-014 valid_o SHALL be 0 in every cycle not immediately following a tick; sample_o and phase_o SHALL hold between ticks.
REQ-015 Quadrant q = ph[5:4], i = ph[3:0]: q0 -> LUT[i]; q1 -> LUT[16-i]; q2 -> -LUT[i]; q3 -> -LUT[16-i].
REQ-016 LUT[0..16] = 0,12,25,37,49,60,71,81,90,98,106,112,117,122,125,126,127 (round(127*sin(2*pi*k/64))).
REQ-017 sample_o SHALL stay in -127..+127; -128 SHALL never be produced.
REQ-018 The controller SHALL be a two-state FSM: IDLE (en=0: cnt, ph, sample_o held, valid_o=0) and RUN (en=1: counting per REQ-012); IDLE->RUN when en rises, RUN->IDLE when en falls, no tick in the cycle en is low.
REQ-019 restart=1 SHALL force cnt=0 and ph=0 in the next cycle and suppress any tick in that cycle; restart has priority over a coincident tick and is honoured in both FSM states.
REQ-020 div=0 SHALL tick every cycle in RUN (valid_o continuously high from the second RUN cycle).
REQ-021 A change of div SHALL take effect at the next compare; if the new div is below the current cnt, the tick SHALL occur on the next cycle (>= compare).

Reset
REQ-022 rst=1 SHALL set cnt=0, ph=0, FSM=IDLE, sample_o=0, phase_o=0, valid_o=0 at the next rising edge; rst has priority over en and restart.
REQ-023 Reset asserted mid-period SHALL discard the partial count; the first sample after reset SHALL be phase 0 (value 0).

Structure
REQ-024 Package sine_pkg SHALL hold SAMPLE_W, PHASE_W=6, the 17-entry LUT constant, and the FSM state typedef {IDLE, RUN}.
REQ-025 One sub-module, sine_quarter_lut, SHALL be the combinational 5-bit-index ROM; quadrant folding and negation live in sine_sample_gen.
REQ-026 Target size 120-400 lines RTL; no multipliers, no clock gating.

Verification
REQ-027 rst, then en=1, div=0 -> valid_o high every cycle; samples 0,12,25,...,127 at phase 16, 0 at 32, -127 at 48, 0 again at phase 0 after 64 samples.
REQ-028 div=3, en=1 -> valid_o strobes exactly every 4 cycles; phase_o increments by 1 per strobe.
REQ-029 en dropped for 10 cycles at phase 20 -> no strobes, sample_o holds LUT[12]=117; resume continues at phase 21 (value 112).
REQ-030 restart coincident with a tick at phase 40 -> no strobe that cycle; next strobe shows phase 0, sample 0.
REQ-031 rst pulsed mid-period at phase 50, div=5 -> all outputs 0 next cycle; after en, first strobe phase 0 after 6 cycles.
REQ-032 div changed 9 -> 2 while cnt=6 -> tick on the next cycle, then period 3 cycles.
